// File: rtl/mod_exp_par.sv
// ---------------------------------------------------------------------------
// mod_exp_par
// Modular exponentiation result = base^exponent mod modulus, computed with
// right-to-left square-and-multiply. Each squaring/multiplying step runs two
// bit-serial interleaved modular multipliers side by side, so one exponent
// bit costs WIDTH cycles of STEP plus one CHECK cycle.
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : synchronous reset, active low
//   start     : request, sampled only while idle
//   base      : base (any value, may exceed modulus)
//   exponent  : exponent
//   modulus   : modulus (legal when >= 2)
//   result    : base^exponent mod modulus, held until the next done
//   busy      : high whenever the engine is not idle
//   done      : one-cycle pulse, valid together with result
//   err       : set with done when modulus < 2, cleared by the next start
// ---------------------------------------------------------------------------
module mod_exp_par #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      REDUCE,
      CHECK,
      STEP,
      FIN
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] base_q;
   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] mod_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] br_q;
   logic [WIDTH:0]   acc1_q;
   logic [WIDTH:0]   acc2_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   mul1_next;
   logic [WIDTH:0]   mul2_next;

   // One MSB-first interleaved multiply step. acc and addend are both below
   // m, so 2*acc and acc+addend stay below 2m and a single conditional
   // subtraction restores the invariant acc < m.
   function automatic logic [WIDTH:0] mm_step(
      input logic [WIDTH:0]   acc,
      input logic [WIDTH-1:0] addend,
      input logic             mbit,
      input logic [WIDTH-1:0] m
   );
      logic [WIDTH:0] t;
      logic [WIDTH:0] mx;
      mx = {1'b0, m};
      t  = acc << 1;
      if (t >= mx) t = t - mx;
      if (mbit) begin
         t = t + {1'b0, addend};
         if (t >= mx) t = t - mx;
      end
      return t;
   endfunction

   // Multiplier datapath. In REDUCE the base itself is the multiplier bit
   // stream against a multiplicand of 1, which folds an out-of-range base
   // into [0, m) without needing it to be reduced first. In STEP both
   // multipliers read the pre-step res and b_r, which stay constant for
   // the whole step.
   always_comb begin
      mul1_next = '0;
      mul2_next = '0;
      case (state)
         REDUCE: begin
            mul1_next = mm_step(acc1_q, WIDTH'(1), base_q[cnt_q], mod_q);
         end
         STEP: begin
            mul1_next = mm_step(acc1_q, br_q, res_q[cnt_q], mod_q);
            mul2_next = mm_step(acc2_q, br_q, br_q[cnt_q], mod_q);
         end
         default: begin
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic and the state-decoded outputs busy/done.
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = (state == FIN);
      case (state)
         IDLE: begin
            if (start) begin
               if (modulus < WIDTH'(2)) state_next = FIN;
               else                     state_next = REDUCE;
            end
         end
         REDUCE: begin
            if (cnt_q == '0) state_next = CHECK;
         end
         CHECK: begin
            if (exp_q == '0) state_next = FIN;
            else             state_next = STEP;
         end
         STEP: begin
            if (cnt_q == '0) state_next = CHECK;
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand latches, exponentiation registers and the result/err outputs.
   // result is loaded on the transition into FIN so that it is already
   // valid during the cycle in which done is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         base_q <= '0;
         exp_q  <= '0;
         mod_q  <= '0;
         res_q  <= WIDTH'(1);
         br_q   <= '0;
         acc1_q <= '0;
         acc2_q <= '0;
         cnt_q  <= '0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_q <= base;
                  exp_q  <= exponent;
                  mod_q  <= modulus;
                  res_q  <= WIDTH'(1);
                  br_q   <= '0;
                  acc1_q <= '0;
                  acc2_q <= '0;
                  cnt_q  <= CNT_MAX;
                  err    <= 1'b0;
                  if (modulus < WIDTH'(2)) begin
                     err    <= 1'b1;
                     result <= '0;
                  end
               end
            end
            REDUCE: begin
               acc1_q <= mul1_next;
               if (cnt_q == '0) br_q <= mul1_next[WIDTH-1:0];
               else             cnt_q <= cnt_q - 1'b1;
            end
            CHECK: begin
               acc1_q <= '0;
               acc2_q <= '0;
               cnt_q  <= CNT_MAX;
               if (exp_q == '0) result <= res_q;
            end
            STEP: begin
               acc1_q <= mul1_next;
               acc2_q <= mul2_next;
               if (cnt_q == '0) begin
                  if (exp_q[0]) res_q <= mul1_next[WIDTH-1:0];
                  br_q  <= mul2_next[WIDTH-1:0];
                  exp_q <= exp_q >> 1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_exp_par.sv
// ---------------------------------------------------------------------------
// tb_mod_exp_par
// Self-checking bench for mod_exp_par at WIDTH 8, 16 and 32. Each request
// pushes its expected result, err flag and done latency onto a scoreboard
// queue; the entry is popped and compared when the DUT raises done.
// ---------------------------------------------------------------------------
module tb_mod_exp_par;

   typedef struct {
      logic [31:0] result;
      logic        err;
      int          latency;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start16, start32;
   logic [31:0] op_base, op_exp, op_mod;

   logic [7:0]  res8;
   logic [15:0] res16;
   logic [31:0] res32;
   logic        busy8, busy16, busy32;
   logic        done8, done16, done32;
   logic        err8, err16, err32;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc;

   always #5 clk = ~clk;

   mod_exp_par #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .base(op_base[7:0]), .exponent(op_exp[7:0]), .modulus(op_mod[7:0]),
      .result(res8), .busy(busy8), .done(done8), .err(err8)
   );

   mod_exp_par #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16),
      .base(op_base[15:0]), .exponent(op_exp[15:0]), .modulus(op_mod[15:0]),
      .result(res16), .busy(busy16), .done(done16), .err(err16)
   );

   mod_exp_par #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32),
      .base(op_base), .exponent(op_exp), .modulus(op_mod),
      .result(res32), .busy(busy32), .done(done32), .err(err32)
   );

   function automatic logic [31:0] mask(input int w, input logic [31:0] v);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return v & m[31:0];
   endfunction

   function automatic logic [31:0] dut_result(input int w);
      case (w)
         8:       return {24'b0, res8};
         16:      return {16'b0, res16};
         default: return res32;
      endcase
   endfunction

   function automatic logic dut_done(input int w);
      case (w)
         8:       return done8;
         16:      return done16;
         default: return done32;
      endcase
   endfunction

   function automatic logic dut_busy(input int w);
      case (w)
         8:       return busy8;
         16:      return busy16;
         default: return busy32;
      endcase
   endfunction

   function automatic logic dut_err(input int w);
      case (w)
         8:       return err8;
         16:      return err16;
         default: return err32;
      endcase
   endfunction

   // Reference square-and-multiply using the % operator on 64-bit values.
   function automatic logic [31:0] model_exp(input int w, input logic [31:0] b,
                                             input logic [31:0] e, input logic [31:0] m);
      longint unsigned mm, r, bb;
      mm = {32'b0, m};
      if (mm < 2) return 32'd0;
      r  = 1;
      bb = {32'b0, b} % mm;
      for (int i = 0; i < w; i++) begin
         if (e[i]) r = (r * bb) % mm;
         bb = (bb * bb) % mm;
      end
      return r[31:0];
   endfunction

   function automatic int model_lat(input int w, input logic [31:0] e, input logic [31:0] m);
      int k;
      if (m < 2) return 1;
      k = 0;
      for (int i = 0; i < w; i++) if (e[i]) k = i + 1;
      return (k + 1) * (w + 1) + 1;
   endfunction

   task automatic set_start(input int w, input logic v);
      case (w)
         8:       start8  = v;
         16:      start16 = v;
         default: start32 = v;
      endcase
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Called just after a rising edge with the selected DUT idle.
   task automatic apply_stimulus(input int w, input logic [31:0] b,
                                 input logic [31:0] e, input logic [31:0] m);
      exp_t x;
      op_base = mask(w, b);
      op_exp  = mask(w, e);
      op_mod  = mask(w, m);
      x.result  = model_exp(w, op_base, op_exp, op_mod);
      x.err     = (op_mod < 2);
      x.latency = model_lat(w, op_exp, op_mod);
      sb_q.push_back(x);
      set_start(w, 1'b1);
   endtask

   // Waits for done, counting cycles from the edge that sampled start.
   // At cycle disturb_cyc a one-cycle start with scrambled operands is
   // driven, which the busy DUT must ignore.
   task automatic check_output(input int w, input int disturb_cyc, input string tag);
      exp_t x;
      logic seen;
      logic busy_ok;
      @(posedge clk);
      #1;
      set_start(w, 1'b0);
      cyc     = 1;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (!seen && cyc <= 1200) begin
         @(negedge clk);
         if (!dut_busy(w)) busy_ok = 1'b0;
         if (dut_done(w)) begin
            seen = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == disturb_cyc) begin
               op_base = ~op_base;
               op_exp  = op_exp ^ 32'h5;
               op_mod  = op_mod + 32'd3;
               set_start(w, 1'b1);
            end else begin
               set_start(w, 1'b0);
            end
         end
      end
      x = sb_q.pop_front();
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         check({tag, "_latency"}, 64'(cyc), 64'(x.latency));
         check({tag, "_result"}, 64'(dut_result(w)), 64'(x.result));
         check({tag, "_err"}, 64'(dut_err(w)), 64'(x.err));
         check({tag, "_busy_during_op"}, 64'(busy_ok), 64'd1);
      end
      @(posedge clk);
      #1;
      check({tag, "_idle_after_done"}, 64'(dut_busy(w)), 64'd0);
   endtask

   initial begin
      logic        got_done;
      logic [31:0] rb, re, rm;
      int          widths[3];
      widths[0] = 8;
      widths[1] = 16;
      widths[2] = 32;

      $display("[TB] starting mod_exp_par bench");
      rst = 1'b0;
      start8 = 1'b0; start16 = 1'b0; start32 = 1'b0;
      op_base = '0; op_exp = '0; op_mod = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset_result", 64'(dut_result(widths[i])), 64'd0);
         check("reset_busy",   64'(dut_busy(widths[i])),   64'd0);
         check("reset_done",   64'(dut_done(widths[i])),   64'd0);
         check("reset_err",    64'(dut_err(widths[i])),    64'd0);
      end
      rst = 1'b1;

      // Directed WIDTH=16 cases, including base above modulus and e = 0.
      apply_stimulus(16, 32'd4, 32'd13, 32'd497);
      check_output(16, 0, "w16_4_13_497");
      apply_stimulus(16, 32'd10, 32'd3, 32'd7);
      check_output(16, 0, "w16_10_3_7");
      apply_stimulus(16, 32'd300, 32'd0, 32'd7);
      check_output(16, 0, "w16_300_0_7");
      apply_stimulus(16, 32'd0, 32'd0, 32'd11);
      check_output(16, 0, "w16_base0_exp0");
      apply_stimulus(16, 32'd0, 32'd9, 32'd11);
      check_output(16, 0, "w16_base0_exp9");

      // Illegal modulus: immediate done with err, err held until next start.
      apply_stimulus(16, 32'd5, 32'd3, 32'd1);
      check_output(16, 0, "w16_mod1");
      check("w16_err_held", 64'(err16), 64'd1);
      apply_stimulus(16, 32'd3, 32'd4, 32'd5);
      check_output(16, 0, "w16_err_cleared");

      // WIDTH=32 boundary values.
      apply_stimulus(32, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFB);
      check_output(32, 0, "w32_fermat");
      apply_stimulus(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_output(32, 0, "w32_all_ones");

      // Start pulse in the middle of STEP must be ignored.
      apply_stimulus(16, 32'd4, 32'd13, 32'd497);
      check_output(16, 30, "w16_start_while_busy");

      // Reset in the middle of STEP: abort, no done, outputs back to reset.
      op_base = 32'd4; op_exp = 32'd13; op_mod = 32'd497;
      start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("abort_result", 64'(res16),  64'd0);
      check("abort_busy",   64'(busy16), 64'd0);
      check("abort_done",   64'(done16), 64'd0);
      check("abort_err",    64'(err16),  64'd0);
      got_done = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (done16) got_done = 1'b1;
      end
      check("abort_no_done", 64'(got_done), 64'd0);
      @(posedge clk);
      #1;
      apply_stimulus(16, 32'd7, 32'd10, 32'd1000);
      check_output(16, 0, "w16_after_abort");

      // Random regression on all three widths.
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 4; n++) begin
            rb = mask(widths[i], $urandom);
            re = mask(widths[i], $urandom) >> $urandom_range(0, widths[i]);
            rm = mask(widths[i], $urandom);
            if (rm < 2) rm = rm + 32'd2;
            apply_stimulus(widths[i], rb, re, rm);
            check_output(widths[i], 0, $sformatf("rand_w%0d_%0d", widths[i], n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mod_exp_par.md
MOD_EXP_PAR -- requirements
Module: mod_exp_par

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.

Interface
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 base  input  WIDTH  base; any value, including values >= modulus.
REQ-006 exponent  input  WIDTH  exponent.
REQ-007 modulus  input  WIDTH  modulus; legal when >= 2.
REQ-008 result  output  WIDTH  base^exponent mod modulus; held until the next done.
REQ-009 busy  output  1  high in every state other than IDLE.
REQ-010 done  output  1  one-cycle pulse, coincident with result update.
REQ-011 err  output  1  high with done when modulus < 2; cleared at the next accepted start.

Function
REQ-012 States SHALL be IDLE, REDUCE, CHECK, STEP and FIN; the state SHALL be held in a register.
REQ-013 IDLE, start=1: latch base, exponent and modulus; go to REDUCE with bit counter = WIDTH-1, res = 1, err cleared; later input changes SHALL be ignored until IDLE.
REQ-014 IDLE, start=1 with modulus < 2: go directly to FIN with err=1 and result forced to 0.
REQ-015 Modular multiply SHALL be interleaved, MSB-first, one multiplier bit per cycle over WIDTH cycles: acc = 2*acc mod m, then acc = (acc + b) mod m if the bit is 1; internal width WIDTH+1 bits; no divider or % operator.
REQ-016 REDUCE (WIDTH cycles) SHALL compute b_r = base*1 mod m; go to CHECK.
REQ-017 CHECK (1 cycle): if e == 0, go to FIN; else go to STEP with counter = WIDTH-1.
REQ-018 STEP (WIDTH cycles) SHALL run two multipliers in parallel on the pre-step values: P1 = res*b_r mod m and P2 = b_r*b_r mod m.
REQ-019 At STEP end: res <= P1 if e[0]=1, else unchanged; b_r <= P2; e <= e>>1; go to CHECK.
REQ-020 FIN (1 cycle): result <= res (or 0 on error); done=1; next state IDLE.
REQ-021 Latency SHALL be fixed: if start is sampled in cycle 0 and k is the bit-length of the exponent (k=0 for exponent 0), done SHALL be high in cycle (k+1)*(WIDTH+1)+1; on error, done SHALL be high in cycle 1.
REQ-022 Exponent 0 SHALL give result 1, including base 0; base 0 with exponent > 0 SHALL give 0.
REQ-023 start while busy SHALL be ignored and not queued; start in the FIN cycle SHALL be ignored.
REQ-024 start held high SHALL begin a new operation in the first IDLE cycle after FIN.
REQ-025 All intermediate values SHALL stay < m; result SHALL always be < modulus when err=0.

Reset
REQ-026 rst=0 at a clock edge SHALL force: state IDLE; result=0; done=0; busy=0; err=0; internal registers cleared, with res=1.
REQ-027 Reset mid-operation SHALL abort the operation with no done pulse; the first start after rst returns high SHALL be accepted normally.
REQ-028 No output SHALL change during reset except to its reset value.

Verification
REQ-029 WIDTH=16: base=4, exponent=13, modulus=497 -> result=445, err=0, done in cycle 86 (k=4), busy high cycles 1..86.
REQ-030 WIDTH=16: base=10, exponent=3, modulus=7 (base > modulus) -> result=6, done in cycle 52; then base=300, exponent=0, modulus=7 -> result=1, done in cycle 18.
REQ-031 WIDTH=32: base=2, exponent=0xFFFFFFFA, modulus=0xFFFFFFFB -> result=1; base=0xFFFFFFFF, exponent=0xFFFFFFFF, modulus=0xFFFFFFFF -> result=0; done in cycle 33*33+1=1090.
REQ-032 WIDTH=16: modulus=1 -> done in cycle 1, err=1, result=0; next legal start clears err.
REQ-033 WIDTH=16: start pulsed during STEP with different operands -> ignored, first result unaffected; rst=0 for 1 cycle mid-STEP -> no done, all outputs 0, next start yields correct result with nominal latency.
REQ-034 Random regression, WIDTH in {8,16,32}: result SHALL match a reference model and the latency formula for every operation.
